// File: rtl/sar_adc_scan_ideal.sv
// Ideal multi-channel SAR ADC: scans a latched channel mask in ascending order,
// converting each held sample MSB-first against a bit-exact comparator.
module sar_adc_scan_ideal #(
   parameter int WIDTH        = 10,
   parameter int CHANNELS     = 4,
   parameter int CLK_DIV      = 2,
   parameter int SAMPLE_TICKS = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [CHANNELS*WIDTH-1:0]  input_voltage_real,
   input  logic [CHANNELS-1:0]        channel_mask,
   input  logic                       continuous,
   input  logic                       start,
   output logic                       busy,
   output logic                       eoc,
   output logic [WIDTH-1:0]           result,
   output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] result_channel
);
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TW = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

   state_t              state;
   logic [DW-1:0]       div;
   logic [TW-1:0]       stk;
   logic [IW-1:0]       bit_i;
   logic [WIDTH-1:0]    sar, held, trial, sel;
   logic [CHANNELS-1:0] mask_q;
   logic [CW-1:0]       ch;
   logic [CW:0]         first_in, first_q, next_q;
   logic                tick;

   // {found, index} of the lowest set bit of m strictly above 'above'
   function automatic logic [CW:0] find_set(input logic [CHANNELS-1:0] m, input int above);
      logic [CW:0] r;
      r = '0;
      for (int c = CHANNELS-1; c >= 0; c--)
         if (m[c] && c > above) r = {1'b1, CW'(c)};
      return r;
   endfunction

   always_comb begin
      tick     = (div == DW'(CLK_DIV-1));
      trial    = sar | (WIDTH'(1) << bit_i);
      sel      = input_voltage_real[ch*WIDTH +: WIDTH];
      first_in = find_set(channel_mask, -1);
      first_q  = find_set(mask_q, -1);
      next_q   = find_set(mask_q, int'(ch));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         div            <= '0;
         stk            <= '0;
         bit_i          <= '0;
         sar            <= '0;
         held           <= '0;
         mask_q         <= '0;
         ch             <= '0;
         busy           <= 1'b0;
         eoc            <= 1'b0;
         result         <= '0;
         result_channel <= '0;
      end else begin
         eoc <= 1'b0;
         if (state != IDLE) div <= tick ? '0 : div + 1'b1;
         case (state)
            IDLE: if (start && first_in[CW]) begin
               mask_q <= channel_mask;
               ch     <= first_in[CW-1:0];
               busy   <= 1'b1;
               div    <= '0;
               stk    <= '0;
               state  <= SAMPLE;
            end
            SAMPLE: if (tick) begin
               if (stk == TW'(SAMPLE_TICKS-1)) begin
                  held  <= sel;
                  sar   <= '0;
                  bit_i <= IW'(WIDTH-1);
                  state <= CONVERT;
               end else begin
                  stk <= stk + 1'b1;
               end
            end
            CONVERT: if (tick) begin
               if (held >= trial) sar <= trial;
               if (bit_i == '0) state <= DONE;
               else             bit_i <= bit_i - 1'b1;
            end
            DONE: begin
               eoc            <= 1'b1;
               result         <= sar;
               result_channel <= ch;
               div            <= '0;
               stk            <= '0;
               // continuous is sampled live here so clearing it mid-scan ends after this scan
               if (next_q[CW]) begin
                  ch    <= next_q[CW-1:0];
                  state <= SAMPLE;
               end else if (continuous && first_q[CW]) begin
                  ch    <= first_q[CW-1:0];
                  state <= SAMPLE;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sar_adc_scan_ideal.sv
// Bench for sar_adc_scan_ideal: table vectors, directed corner sequences and
// randomized traffic, all checked every cycle against an edge-counting model.
module tb_sar_adc_scan_ideal;
   localparam int W    = 10;
   localparam int C    = 4;
   localparam int CD   = 2;
   localparam int ST   = 2;
   localparam int CONV = (ST + W) * CD + 1;

   logic           clk = 1'b0;
   logic           reset = 1'b1, continuous = 1'b0, start = 1'b0;
   logic [C*W-1:0] vin = '0;
   logic [C-1:0]   mask = '0;
   logic           busy, eoc;
   logic [W-1:0]   result;
   logic [1:0]     result_channel;

   always #5 clk = ~clk;

   sar_adc_scan_ideal #(.WIDTH(W), .CHANNELS(C), .CLK_DIV(CD), .SAMPLE_TICKS(ST)) dut (
      .clk(clk), .reset(reset), .input_voltage_real(vin), .channel_mask(mask),
      .continuous(continuous), .start(start), .busy(busy), .eoc(eoc),
      .result(result), .result_channel(result_channel));

   int total = 0, bad = 0, cyc = 0;

   // model: a conversion is CONV edges long; sample taken ST*CD edges in
   bit           m_act = 0, m_eoc = 0;
   logic [C-1:0] m_mask = '0;
   int           m_ch = 0, m_age = 0, m_rch = 0;
   logic [W-1:0] m_held = '0, m_res = '0;

   logic [W-1:0] ev_res[$];
   int           ev_ch[$], ev_cyc[$];

   function automatic int lowest_above(input logic [C-1:0] m, input int from);
      for (int c = from + 1; c < C; c++) if (m[c]) return c;
      return -1;
   endfunction

   function automatic logic [W-1:0] rand_code();
      case ($urandom_range(0, 3))
         0: return '0;
         1: return '1;
         default: return W'($urandom);
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_edge();
      m_eoc = 0;
      if (reset) begin
         m_act = 0; m_res = '0; m_rch = 0; m_held = '0;
      end else if (!m_act) begin
         if (start && mask != '0) begin
            m_act = 1; m_mask = mask; m_ch = lowest_above(mask, -1); m_age = 0;
         end
      end else begin
         m_age++;
         if (m_age == ST * CD) m_held = vin[m_ch*W +: W];
         if (m_age == CONV) begin
            m_eoc = 1; m_res = m_held; m_rch = m_ch; m_age = 0;
            m_ch = lowest_above(m_mask, m_ch);
            if (m_ch < 0) begin
               if (continuous) m_ch = lowest_above(m_mask, -1);
               else m_act = 0;
            end
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      chk("busy", 32'(busy), 32'(m_act));
      chk("eoc", 32'(eoc), 32'(m_eoc));
      chk("result", 32'(result), 32'(m_res));
      chk("result_channel", 32'(result_channel), 32'(m_rch));
      if (eoc) begin
         ev_res.push_back(result); ev_ch.push_back(int'(result_channel)); ev_cyc.push_back(cyc);
      end
   endtask

   task automatic clear_ev();
      ev_res.delete(); ev_ch.delete(); ev_cyc.delete();
   endtask

   // pulse start for one edge; returns the cycle number of the accepting edge
   task automatic pulse_start(output int k);
      start = 1'b1;
      step();
      start = 1'b0;
      k = cyc;
   endtask

   typedef struct {
      logic [C-1:0]   mask;
      logic [C*W-1:0] data;
      int             cnt;
      logic [W-1:0]   r0;
      int             c0;
      logic [W-1:0]   r1;
      int             c1;
   } vec_t;

   vec_t vt[5];

   initial begin
      int k;
      vt[0] = '{4'b0001, {10'h033, 10'h022, 10'h011, 10'h1A4}, 1, 10'h1A4, 0, 10'h1A4, 0};
      vt[1] = '{4'b1010, {10'h3FF, 10'h155, 10'h000, 10'h2AA}, 2, 10'h000, 1, 10'h3FF, 3};
      vt[2] = '{4'b1111, {10'h2AA, 10'h155, 10'h000, 10'h3FF}, 4, 10'h3FF, 0, 10'h2AA, 3};
      vt[3] = '{4'b0100, {10'h001, 10'h200, 10'h3FE, 10'h0FF}, 1, 10'h200, 2, 10'h200, 2};
      vt[4] = '{4'b1000, {10'h001, 10'h123, 10'h321, 10'h0F0}, 1, 10'h001, 3, 10'h001, 3};

      step(); step();
      chk("reset_busy", 32'(busy), 0);
      chk("reset_result", 32'(result), 0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 5; i++) begin
         vin = vt[i].data; mask = vt[i].mask; continuous = 1'b0;
         clear_ev();
         pulse_start(k);
         repeat (C * CONV + 5) step();
         chk("vec_count", 32'(ev_res.size()), 32'(vt[i].cnt));
         if (ev_res.size() == vt[i].cnt) begin
            chk("vec_latency", 32'(ev_cyc[0] - k), 32'(CONV));
            chk("vec_first_res", 32'(ev_res[0]), 32'(vt[i].r0));
            chk("vec_first_ch", 32'(ev_ch[0]), 32'(vt[i].c0));
            chk("vec_last_res", 32'(ev_res[vt[i].cnt-1]), 32'(vt[i].r1));
            chk("vec_last_ch", 32'(ev_ch[vt[i].cnt-1]), 32'(vt[i].c1));
            if (vt[i].cnt > 1) chk("vec_spacing", 32'(ev_cyc[1] - ev_cyc[0]), 32'(CONV));
         end
         chk("vec_idle", 32'(busy), 0);
      end

      // held sample is immune to input changes during CONVERT
      vin = '0; vin[2*W +: W] = 10'h08A; mask = 4'b0100;
      clear_ev();
      pulse_start(k);
      repeat (10) step();
      vin[2*W +: W] = 10'h184;
      repeat (CONV) step();
      chk("hold_count", 32'(ev_res.size()), 1);
      if (ev_res.size() == 1) chk("hold_res", 32'(ev_res[0]), 32'(10'h08A));

      // continuous scans, then drop continuous mid-scan
      vin = {10'h000, 10'h000, 10'h30F, 10'h0F0}; mask = 4'b0011; continuous = 1'b1;
      clear_ev();
      pulse_start(k);
      repeat (6 * CONV + 10) step();
      continuous = 1'b0;
      repeat (2 * CONV + 20) step();
      chk("cont_count", 32'(ev_res.size()), 8);
      for (int i = 0; i < ev_ch.size(); i++) chk("cont_order", 32'(ev_ch[i]), 32'(i % 2));
      chk("cont_idle", 32'(busy), 0);

      // reset mid-CONVERT aborts, then a fresh start converts normally
      vin = {10'h000, 10'h000, 10'h000, 10'h2C3}; mask = 4'b0001;
      clear_ev();
      pulse_start(k);
      repeat (10) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_eoc", 32'(eoc), 0);
      chk("abort_result", 32'(result), 0);
      chk("abort_channel", 32'(result_channel), 0);
      repeat (CONV + 5) step();
      chk("abort_no_eoc", 32'(ev_res.size()), 0);
      pulse_start(k);
      repeat (CONV + 5) step();
      chk("restart_count", 32'(ev_res.size()), 1);
      if (ev_res.size() == 1) begin
         chk("restart_latency", 32'(ev_cyc[0] - k), 32'(CONV));
         chk("restart_res", 32'(ev_res[0]), 32'(10'h2C3));
      end

      // start with empty mask, then starts while busy
      mask = '0;
      clear_ev();
      pulse_start(k);
      chk("empty_mask_busy", 32'(busy), 0);
      repeat (CONV) step();
      chk("empty_mask_eoc", 32'(ev_res.size()), 0);
      vin = {10'h111, 10'h2E2, 10'h0C1, 10'h3A3}; mask = 4'b0110;
      pulse_start(k);
      mask = 4'b1111;
      for (int s = 0; s < 2 * CONV + 10; s++) begin
         start = (s % 3 == 0) && (s < 2 * CONV - 2);
         step();
      end
      start = 1'b0;
      chk("busy_start_count", 32'(ev_res.size()), 2);
      if (ev_res.size() == 2) begin
         chk("busy_start_t0", 32'(ev_cyc[0] - k), 32'(CONV));
         chk("busy_start_t1", 32'(ev_cyc[1] - k), 32'(2 * CONV));
         chk("busy_start_ch0", 32'(ev_ch[0]), 1);
         chk("busy_start_ch1", 32'(ev_ch[1]), 2);
      end

      // randomized traffic
      for (int it = 0; it < 30; it++) begin
         mask = 4'($urandom);
         for (int c = 0; c < C; c++) vin[c*W +: W] = rand_code();
         continuous = ($urandom_range(0, 3) == 0);
         pulse_start(k);
         for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 3) == 0) begin
               int idx;
               idx = $urandom_range(0, C - 1);
               vin[idx*W +: W] = rand_code();
            end
            start = ($urandom_range(0, 19) == 0);
            mask  = 4'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            step();
         end
         start = 1'b0; reset = 1'b0; continuous = 1'b0;
         for (int s = 0; s < 6 * CONV && busy; s++) step();
         chk("rand_idle", 32'(busy), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
